// File: rtl/alu_res_station.sv
// rtl/alu_res_station.sv - six-entry collapsing reservation station for the ALU
// Oldest-first issue with two-bus wakeup; issue removal, dispatch append and wakeup share one edge.
module alu_res_station (
  input  logic         Clk,
  input  logic         Rest,
  input  logic         RsFlash,
  input  logic         Inst1Able,
  input  logic         Inst2Able,
  input  logic         Inst3Able,
  input  logic         Inst4Able,
  input  logic [106:0] Inst1Infor,
  input  logic [106:0] Inst2Infor,
  input  logic [106:0] Inst3Infor,
  input  logic [106:0] Inst4Infor,
  output logic [2:0]   RsFreeNum,
  input  logic         Wb1Able,
  input  logic         Wb2Able,
  input  logic [6:0]   Wb1Addr,
  input  logic [6:0]   Wb2Addr,
  input  logic [31:0]  Wb1Date,
  input  logic [31:0]  Wb2Date,
  output logic         IssueAble,
  output logic [106:0] IssueInfor,
  input  logic         IssueReady,
  output logic         RsOverflow
);

  localparam int DEPTH = 6;
  localparam int PW    = 107;

  logic [PW-1:0]    entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    entry_d [DEPTH];
  logic [DEPTH-1:0] valid_d;

  logic [PW-1:0]    ext [DEPTH+1];
  logic [DEPTH:0]   valid_ext;
  logic [PW-1:0]    shifted [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [2:0]       sel;
  logic [2:0]       count;
  logic [2:0]       count_after;
  logic [2:0]       n_able;
  logic [2:0]       accept_n;
  logic [2:0]       occ_next;
  logic [2:0]       k;
  logic             do_issue;
  logic             overflow_d;
  logic [3:0]       inst_able;
  logic [PW-1:0]    inst_infor [4];
  logic [PW-1:0]    pkts [4];

  // Resolve one source field: Wb1 has priority when both buses carry the tag.
  function automatic logic [32:0] wake_src(input logic [32:0] src,
                                           input logic a1, input logic [6:0] t1, input logic [31:0] d1,
                                           input logic a2, input logic [6:0] t2, input logic [31:0] d2);
    logic [32:0] r;
    r = src;
    if (!src[32]) begin
      if (a1 && src[6:0] == t1)      r = {1'b1, d1};
      else if (a2 && src[6:0] == t2) r = {1'b1, d2};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] wake(input logic [PW-1:0] p,
                                         input logic a1, input logic [6:0] t1, input logic [31:0] d1,
                                         input logic a2, input logic [6:0] t2, input logic [31:0] d2);
    logic [PW-1:0] r;
    r = p;
    r[98:66] = wake_src(p[98:66], a1, t1, d1, a2, t2, d2);
    r[65:33] = wake_src(p[65:33], a1, t1, d1, a2, t2, d2);
    return r;
  endfunction

  assign inst_able     = {Inst4Able, Inst3Able, Inst2Able, Inst1Able};
  assign inst_infor[0] = Inst1Infor;
  assign inst_infor[1] = Inst2Infor;
  assign inst_infor[2] = Inst3Infor;
  assign inst_infor[3] = Inst4Infor;

  always_comb begin
    sel   = '0;
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] & entry_q[i][98] & entry_q[i][65];
      count    = count + {2'b0, valid_q[i]};
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel = 3'(i);
    end
  end

  assign IssueAble  = |ready;
  assign IssueInfor = IssueAble ? entry_q[sel] : '0;
  assign do_issue   = IssueAble & IssueReady;

  // Pack the Able dispatch slots into consecutive positions, Inst1 first.
  always_comb begin
    n_able = '0;
    for (int i = 0; i < 4; i++) pkts[i] = '0;
    for (int i = 0; i < 4; i++) begin
      if (inst_able[i]) begin
        pkts[n_able[1:0]] = inst_infor[i];
        n_able            = n_able + 3'd1;
      end
    end
  end

  // Acceptance is bounded by the registered free count, so an issue this cycle cannot make room.
  assign overflow_d  = n_able > RsFreeNum;
  assign accept_n    = overflow_d ? RsFreeNum : n_able;
  assign count_after = count - {2'b0, do_issue};
  assign occ_next    = count_after + accept_n;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = entry_q[i];
    ext[DEPTH] = '0;
    valid_ext  = {1'b0, valid_q};
    k          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shifted[i] = (do_issue && 3'(i) >= sel) ? ext[i+1] : ext[i];
    end
    for (int j = 0; j < DEPTH; j++) begin
      entry_d[j] = shifted[j];
      valid_d[j] = 1'b0;
      if (3'(j) < count_after) begin
        entry_d[j] = wake(shifted[j], Wb1Able, Wb1Addr, Wb1Date, Wb2Able, Wb2Addr, Wb2Date);
        valid_d[j] = 1'b1;
      end else begin
        k = 3'(j) - count_after;
        if (k < accept_n) begin
          entry_d[j] = wake(pkts[k[1:0]], Wb1Able, Wb1Addr, Wb1Date, Wb2Able, Wb2Addr, Wb2Date);
          valid_d[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest || RsFlash) begin
      valid_q    <= '0;
      RsFreeNum  <= 3'd6;
      RsOverflow <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      RsFreeNum  <= 3'd6 - occ_next;
      RsOverflow <= overflow_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  logic unused_valid_ext;
  assign unused_valid_ext = |valid_ext;

endmodule

// File: tb/tb_alu_res_station.sv
// tb/tb_alu_res_station.sv - randomized and directed checks of alu_res_station against a queue model
module tb_alu_res_station;

  logic         clk = 1'b0;
  logic         rest, flash, issue_ready;
  logic         ia [4];
  logic [106:0] ii [4];
  logic         wb1a, wb2a;
  logic [6:0]   wb1t, wb2t;
  logic [31:0]  wb1d, wb2d;
  logic [2:0]   free_num;
  logic         issue_able, overflow;
  logic [106:0] issue_infor;

  int checks = 0;
  int errors = 0;

  logic [106:0] mq[$];
  logic         m_ovf;

  always #5 clk = ~clk;

  alu_res_station dut (
    .Clk(clk), .Rest(rest), .RsFlash(flash),
    .Inst1Able(ia[0]), .Inst2Able(ia[1]), .Inst3Able(ia[2]), .Inst4Able(ia[3]),
    .Inst1Infor(ii[0]), .Inst2Infor(ii[1]), .Inst3Infor(ii[2]), .Inst4Infor(ii[3]),
    .RsFreeNum(free_num),
    .Wb1Able(wb1a), .Wb2Able(wb2a), .Wb1Addr(wb1t), .Wb2Addr(wb2t), .Wb1Date(wb1d), .Wb2Date(wb2d),
    .IssueAble(issue_able), .IssueInfor(issue_infor), .IssueReady(issue_ready), .RsOverflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [106:0] obs, input logic [106:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [106:0] m_wake(input logic [106:0] p);
    logic [106:0] r;
    r = p;
    if (!p[98]) begin
      if (wb1a && p[72:66] == wb1t)      begin r[97:66] = wb1d; r[98] = 1'b1; end
      else if (wb2a && p[72:66] == wb2t) begin r[97:66] = wb2d; r[98] = 1'b1; end
    end
    if (!p[65]) begin
      if (wb1a && p[39:33] == wb1t)      begin r[64:33] = wb1d; r[65] = 1'b1; end
      else if (wb2a && p[39:33] == wb2t) begin r[64:33] = wb2d; r[65] = 1'b1; end
    end
    return r;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i][98] && mq[i][65]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int s, room, n;
    if (rest || flash) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    room = 6 - mq.size();
    s    = m_sel();
    if (s >= 0 && issue_ready) mq.delete(s);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (ia[i]) begin
        if (n < room) mq.push_back(ii[i]);
        n++;
      end
    end
    m_ovf = (n > room);
    for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
  endtask

  task automatic compare(input string tag);
    int s;
    s = m_sel();
    check_eq({tag, ".able"}, {106'b0, issue_able}, {106'b0, s >= 0});
    check_eq({tag, ".infor"}, issue_infor, (s >= 0) ? mq[s] : 107'b0);
    check_eq({tag, ".free"}, {104'b0, free_num}, 107'(6 - mq.size()));
    check_eq({tag, ".ovf"}, {106'b0, overflow}, {106'b0, m_ovf});
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic idle();
    rest = 0; flash = 0; issue_ready = 0;
    wb1a = 0; wb2a = 0; wb1t = '0; wb2t = '0; wb1d = '0; wb2d = '0;
    for (int i = 0; i < 4; i++) begin ia[i] = 0; ii[i] = '0; end
  endtask

  function automatic logic [106:0] mk(input logic [7:0] op, input logic s1a, input logic [31:0] s1,
                                      input logic s2a, input logic [31:0] s2);
    return {op, s1a, s1, s2a, s2, 1'b1, 32'h5};
  endfunction

  function automatic logic [106:0] rnd_pkt();
    logic [31:0] s1, s2;
    logic        a1, a2;
    s1 = $urandom; s2 = $urandom;
    a1 = ($urandom_range(0, 1) == 1);
    a2 = ($urandom_range(0, 1) == 1);
    if (!a1) s1[6:0] = 7'(8'h20 + $urandom_range(0, 7));
    if (!a2) s2[6:0] = 7'(8'h20 + $urandom_range(0, 7));
    return {8'($urandom), a1, s1, a2, s2, 1'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [106:0] pa, pb, pv;
    idle();
    rest = 1;
    cycle("reset");
    rest = 0;
    cycle("post_reset");
    check_eq("r019.free", {104'b0, free_num}, 107'd6);
    check_eq("r019.able", {106'b0, issue_able}, 107'd0);

    // Ready packet issues the cycle after dispatch and frees its slot the cycle after that.
    ia[0] = 1; ii[0] = mk(8'h11, 1, 32'hA, 1, 32'hB); issue_ready = 1;
    cycle("r020a");
    ia[0] = 0;
    check_eq("r020.able", {106'b0, issue_able}, 107'd1);
    pv = issue_infor;
    check_eq("r020.op", {99'b0, pv[106:99]}, 107'h11);
    cycle("r020b");
    check_eq("r020.free", {104'b0, free_num}, 107'd6);

    issue_ready = 0;
    ia[0] = 1; ii[0] = mk(8'h22, 0, 32'h23, 1, 32'h7);
    cycle("r021a");
    ia[0] = 0;
    wb1a = 1; wb1t = 7'h23; wb1d = 32'hDEADBEEF;
    cycle("r021b");
    wb1a = 0;
    check_eq("r021.able", {106'b0, issue_able}, 107'd1);
    pv = issue_infor;
    check_eq("r021.data", {75'b0, pv[97:66]}, 107'hDEADBEEF);

    flash = 1; cycle("flush1"); flash = 0;
    for (int i = 0; i < 4; i++) begin ia[i] = 1; ii[i] = mk(8'(i), 0, 32'h7F, 1, 32'h1); end
    cycle("r022a");
    ia[2] = 0; ia[3] = 0;
    cycle("r022b");
    cycle("r022c");
    check_eq("r022.ovf", {106'b0, overflow}, 107'd1);
    check_eq("r022.free", {104'b0, free_num}, 107'd0);
    ia[0] = 0; ia[1] = 0;
    cycle("r022d");
    check_eq("r022.ovf_clr", {106'b0, overflow}, 107'd0);
    check_eq("r022.free_hold", {104'b0, free_num}, 107'd0);

    flash = 1; cycle("flush2"); flash = 0;
    pa = mk(8'hAA, 1, 32'h1, 1, 32'h2);
    pb = mk(8'hBB, 1, 32'h3, 1, 32'h4);
    ia[0] = 1; ii[0] = pa; ia[1] = 1; ii[1] = pb;
    cycle("r023a");
    ia[0] = 0; ia[1] = 0;
    for (int c = 0; c < 3; c++) begin
      check_eq("r023.hold", issue_infor, pa);
      cycle("r023h");
    end
    check_eq("r023.hold4", issue_infor, pa);
    issue_ready = 1;
    cycle("r023i");
    check_eq("r023.next", issue_infor, pb);
    issue_ready = 0;

    flash = 1; cycle("flush3"); flash = 0;
    for (int i = 0; i < 4; i++) begin ia[i] = 1; ii[i] = mk(8'(i), 0, 32'h7E, 0, 32'h7E); end
    cycle("r024a");
    ia[2] = 0; ia[3] = 0; flash = 1; issue_ready = 1;
    cycle("r024b");
    check_eq("r024.free", {104'b0, free_num}, 107'd6);
    check_eq("r024.able", {106'b0, issue_able}, 107'd0);
    idle();

    for (int c = 0; c < 600; c++) begin
      rest        = ($urandom_range(0, 99) == 0);
      flash       = ($urandom_range(0, 39) == 0);
      issue_ready = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < 4; i++) begin
        ia[i] = ($urandom_range(0, 9) < 3);
        ii[i] = rnd_pkt();
      end
      wb1a = ($urandom_range(0, 1) == 1); wb1t = 7'(8'h20 + $urandom_range(0, 7)); wb1d = $urandom;
      wb2a = ($urandom_range(0, 1) == 1); wb2t = 7'(8'h20 + $urandom_range(0, 7)); wb2d = $urandom;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
